ordered_set_generator: RTL

ORDERED_SET_GENERATOR -- requirements
Module: ordered_set_generator

---
 rtl/aurora_pkg.sv | 73 +++++++
 rtl/idle_lfsr.sv | 31 +++
 rtl/ordered_set_generator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/aurora_pkg.sv
// Ordered-set codes (13-bit one-hot), symbol bytes and the per-set symbol table
// shared by the ordered-set generator and its bench.
package aurora_pkg;

  localparam int OS_W             = 13;
  localparam int OS_LEN_MAX       = 4;
  localparam int MAX_SEQ_LEN_DFLT = 4;

  typedef logic [OS_W-1:0] ordered_sets_t;
  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  localparam ordered_sets_t OS_SP  = 13'h0001;
  localparam ordered_sets_t OS_SPA = 13'h0002;
  localparam ordered_sets_t OS_VER = 13'h0004;
  localparam ordered_sets_t OS_SCP = 13'h0008;
  localparam ordered_sets_t OS_ECP = 13'h0010;
  localparam ordered_sets_t OS_P   = 13'h0020;
  localparam ordered_sets_t OS_SUF = 13'h0040;
  localparam ordered_sets_t OS_K   = 13'h0080;
  localparam ordered_sets_t OS_R   = 13'h0100;
  localparam ordered_sets_t OS_A   = 13'h0200;
  localparam ordered_sets_t OS_CC  = 13'h0400;
  localparam ordered_sets_t OS_SNF = 13'h0800;
  localparam ordered_sets_t OS_I   = 13'h1000;

  localparam logic [7:0] SYM_K28_5 = 8'hBC;
  localparam logic [7:0] SYM_SP_D  = 8'h4A;
  localparam logic [7:0] SYM_SPA_D = 8'h2C;
  localparam logic [7:0] SYM_VER_D = 8'hE8;
  localparam logic [7:0] SYM_SCP_0 = 8'h5C;
  localparam logic [7:0] SYM_SCP_1 = 8'hFB;
  localparam logic [7:0] SYM_ECP_0 = 8'hFD;
  localparam logic [7:0] SYM_ECP_1 = 8'hFE;
  localparam logic [7:0] SYM_P     = 8'h9C;
  localparam logic [7:0] SYM_R     = 8'h1C;
  localparam logic [7:0] SYM_A     = 8'h7C;
  localparam logic [7:0] SYM_CC    = 8'hF7;
  localparam logic [7:0] SYM_SNF   = 8'hDC;

  localparam logic [7:0] LFSR_SEED = 8'hFF;

  typedef struct packed {
    logic [2:0]                 len;
    logic [OS_LEN_MAX-1:0]      k;
    logic [OS_LEN_MAX-1:0][7:0] sym;
  } os_seq_t;

  function automatic logic os_is_legal(ordered_sets_t t);
    return (t != '0) && ((t & (t - ordered_sets_t'(1))) == '0);
  endfunction

  // sym[0] goes out first; OS_I has no fixed symbols and becomes idle fill.
  function automatic os_seq_t os_lookup(ordered_sets_t t);
    os_seq_t s;
    s = '0;
    case (t)
      OS_SP:        begin s.len = 3'd4; s.k = 4'b0001; s.sym = {SYM_SP_D, SYM_SP_D, SYM_SP_D, SYM_K28_5}; end
      OS_SPA:       begin s.len = 3'd4; s.k = 4'b0001; s.sym = {SYM_SPA_D, SYM_SPA_D, SYM_SPA_D, SYM_K28_5}; end
      OS_VER:       begin s.len = 3'd4; s.k = 4'b0001; s.sym = {SYM_VER_D, SYM_VER_D, SYM_VER_D, SYM_K28_5}; end
      OS_SCP:       begin s.len = 3'd2; s.k = 4'b0011; s.sym = {16'h0000, SYM_SCP_1, SYM_SCP_0}; end
      OS_ECP:       begin s.len = 3'd2; s.k = 4'b0011; s.sym = {16'h0000, SYM_ECP_1, SYM_ECP_0}; end
      OS_P, OS_SUF: begin s.len = 3'd1; s.k = 4'b0001; s.sym = {24'h000000, SYM_P}; end
      OS_K:         begin s.len = 3'd1; s.k = 4'b0001; s.sym = {24'h000000, SYM_K28_5}; end
      OS_R:         begin s.len = 3'd1; s.k = 4'b0001; s.sym = {24'h000000, SYM_R}; end
      OS_A:         begin s.len = 3'd1; s.k = 4'b0001; s.sym = {24'h000000, SYM_A}; end
      OS_CC:        begin s.len = 3'd2; s.k = 4'b0011; s.sym = {16'h0000, SYM_CC, SYM_CC}; end
      OS_SNF:       begin s.len = 3'd1; s.k = 4'b0001; s.sym = {24'h000000, SYM_SNF}; end
      default:      s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/idle_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, reseeded to LFSR_SEED on reset.
// Only instantiated when AURORA_IDLE_LFSR_EN is defined.
module idle_lfsr
  import aurora_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/ordered_set_generator.sv
// Ordered-set generator: LANES symbols per beat, idle fill between sets.
// AURORA_IDLE_LFSR_EN selects LFSR-chosen idles (A/R/K); default idle is K28.5.
//   state   | meaning
//   ST_IDLE | output register holds an idle-fill beat
//   ST_SEND | output register holds an ordered-set beat; cnt_q symbols remain
module ordered_set_generator
  import aurora_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int MAX_SEQ_LEN = MAX_SEQ_LEN_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               os_valid,
  input  logic [OS_W-1:0]    os_type,
  output logic               os_ready,
  input  logic               tx_ready,
  output logic [8*LANES-1:0] tx_data,
  output logic [LANES-1:0]   tx_k,
  output logic               tx_is_os,
  output logic               os_err
);

  localparam int SEQ_LEN = (MAX_SEQ_LEN > OS_LEN_MAX) ? MAX_SEQ_LEN : OS_LEN_MAX;
  // LANES spare slots keep the per-beat shift and lane indexing in range.
  localparam int BUF_LEN = SEQ_LEN + LANES;
  localparam int CW      = $clog2(BUF_LEN + 1);

  state_t                  state_q, state_d;
  logic [BUF_LEN-1:0][7:0] buf_q, buf_d;
  logic [BUF_LEN-1:0]      bufk_q, bufk_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [8*LANES-1:0]      data_q, data_d;
  logic [LANES-1:0]        k_q, k_d;
  logic                    is_os_q, is_os_d;
  logic                    err_q, err_d;

  logic [LANES-1:0][7:0]   idle_sym;
  logic [BUF_LEN-1:0][7:0] src_sym;
  logic [BUF_LEN-1:0]      src_k;
  logic [CW-1:0]           src_len;
  logic                    accept, legal, load_seq;
  os_seq_t                 seq;

`ifdef AURORA_IDLE_LFSR_EN
  logic [7:0] lfsr_state;

  idle_lfsr u_idle_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (tx_ready),
    .state_o (lfsr_state)
  );

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      case (lfsr_state[2*l +: 2])
        2'b00:   idle_sym[l] = SYM_A;
        2'b01:   idle_sym[l] = SYM_R;
        default: idle_sym[l] = SYM_K28_5;
      endcase
    end
  end
`else
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      idle_sym[l] = SYM_K28_5;
    end
  end
`endif

  assign os_ready = rst_n && tx_ready && ((state_q == ST_IDLE) || (cnt_q == '0));
  assign accept   = os_valid && os_ready;
  assign legal    = os_is_legal(os_type);
  assign seq      = os_lookup(os_type);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    bufk_d   = bufk_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    k_d      = k_q;
    is_os_d  = is_os_q;
    err_d    = accept && !legal;
    src_sym  = buf_q;
    src_k    = bufk_q;
    src_len  = cnt_q;
    load_seq = 1'b0;

    if (accept && legal && (seq.len != '0)) begin
      src_sym = '0;
      src_k   = '0;
      for (int i = 0; i < OS_LEN_MAX; i++) begin
        src_sym[i] = seq.sym[i];
        src_k[i]   = seq.k[i];
      end
      src_len  = CW'(seq.len);
      load_seq = 1'b1;
    end else if ((state_q == ST_SEND) && (cnt_q != '0)) begin
      load_seq = 1'b1;
    end

    if (tx_ready) begin
      if (load_seq) begin
        // Lanes past the end of the set are padded with idle symbols.
        for (int l = 0; l < LANES; l++) begin
          if (CW'(l) < src_len) begin
            data_d[8*l +: 8] = src_sym[l];
            k_d[l]           = src_k[l];
          end else begin
            data_d[8*l +: 8] = idle_sym[l];
            k_d[l]           = 1'b1;
          end
        end
        buf_d   = src_sym >> (8 * LANES);
        bufk_d  = src_k >> LANES;
        cnt_d   = (src_len > CW'(LANES)) ? (src_len - CW'(LANES)) : '0;
        is_os_d = 1'b1;
        state_d = ST_SEND;
      end else begin
        data_d  = idle_sym;
        k_d     = '1;
        is_os_d = 1'b0;
        buf_d   = '0;
        bufk_d  = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      bufk_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      k_q     <= '0;
      is_os_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      bufk_q  <= bufk_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      k_q     <= k_d;
      is_os_q <= is_os_d;
      err_q   <= err_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_k     = k_q;
  assign tx_is_os = is_os_q;
  assign os_err   = err_q;

endmodule
